// File: rtl/systolic_output_collector.sv
// rtl/systolic_output_collector.sv - de-skews systolic array bottom-edge columns into packed result rows
// Optional OUT_COLLECTOR_RELU_EN: each element is ReLU'd as it is popped into row_data_o.

module systolic_output_collector #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [15:0]         rows_i,
    input  logic [N-1:0]        col_valid_i,
    input  logic [N*DATA_W-1:0] col_data_i,
    output logic                row_valid_o,
    input  logic                row_ready_i,
    output logic [N*DATA_W-1:0] row_data_o,
    output logic                row_last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q    [N][DEPTH];
    logic [AW-1:0]       wr_ptr_q [N];
    logic [AW-1:0]       rd_ptr_q [N];
    logic [AW:0]         cnt_q    [N];
    logic [15:0]         rows_q;
    logic [15:0]         row_cnt_q;
    logic [N*DATA_W-1:0] row_data_q;
    logic                row_valid_q;
    logic                done_q;
    logic                err_q;

    logic [N-1:0]        full;
    logic [N-1:0]        push;
    logic [N-1:0]        overflow;
    logic                all_nonempty;
    logic                pop;
    logic                hs;
    logic                last_hs;
    logic                fifo_clr;
    logic                err_set;
    logic                err_clr;
    logic [N*DATA_W-1:0] row_next;

    always_comb begin
        all_nonempty = 1'b1;
        full         = '0;
        for (int j = 0; j < N; j++) begin
            if (cnt_q[j] == '0) all_nonempty = 1'b0;
            full[j] = (cnt_q[j] == FULL_CNT);
        end
    end

    assign pop      = (state_q == COLLECT) && all_nonempty && (!row_valid_q || row_ready_i);
    assign hs       = row_valid_q && row_ready_i;
    assign last_hs  = (state_q == COLLECT) && hs && (row_cnt_q == rows_q - 16'd1);
    assign fifo_clr = (state_q == IDLE) || last_hs;

    // A full column may still accept when the row pops in the same cycle.
    always_comb begin
        push     = '0;
        overflow = '0;
        for (int j = 0; j < N; j++) begin
            if (state_q == COLLECT && col_valid_i[j]) begin
                if (full[j] && !pop) overflow[j] = 1'b1;
                else                 push[j]     = !last_hs;
            end
        end
    end

    always_comb begin
        row_next = '0;
        for (int j = 0; j < N; j++) begin
`ifdef OUT_COLLECTOR_RELU_EN
            row_next[j*DATA_W +: DATA_W] = mem_q[j][rd_ptr_q[j]][DATA_W-1] ?
                                           '0 : mem_q[j][rd_ptr_q[j]];
`else
            row_next[j*DATA_W +: DATA_W] = mem_q[j][rd_ptr_q[j]];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        err_clr = 1'b0;
        err_set = |overflow;
        case (state_q)
            IDLE: begin
                err_clr = start_i;
                if (|col_valid_i) err_set = 1'b1;
                if (start_i && rows_i != 16'd0) state_d = COLLECT;
            end
            COLLECT: begin
                if (start_i) err_set = 1'b1;
                if (last_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (push[j]) mem_q[j][wr_ptr_q[j]] <= col_data_i[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            row_cnt_q   <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int j = 0; j < N; j++) begin
                wr_ptr_q[j] <= '0;
                rd_ptr_q[j] <= '0;
                cnt_q[j]    <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= last_hs || (state_q == IDLE && start_i && rows_i == 16'd0);
            err_q   <= err_set || (err_q && !err_clr);

            for (int j = 0; j < N; j++) begin
                if (fifo_clr) begin
                    wr_ptr_q[j] <= '0;
                    rd_ptr_q[j] <= '0;
                    cnt_q[j]    <= '0;
                end else begin
                    if (push[j]) wr_ptr_q[j] <= wr_ptr_q[j] + 1'b1;
                    if (pop)     rd_ptr_q[j] <= rd_ptr_q[j] + 1'b1;
                    case ({push[j], pop})
                        2'b10:   cnt_q[j] <= cnt_q[j] + 1'b1;
                        2'b01:   cnt_q[j] <= cnt_q[j] - 1'b1;
                        default: cnt_q[j] <= cnt_q[j];
                    endcase
                end
            end

            if (pop && !last_hs) begin
                row_valid_q <= 1'b1;
                row_data_q  <= row_next;
            end else if (hs) begin
                row_valid_q <= 1'b0;
            end

            if (state_q == IDLE && start_i) begin
                rows_q    <= rows_i;
                row_cnt_q <= '0;
            end else if (state_q == COLLECT && hs) begin
                row_cnt_q <= row_cnt_q + 16'd1;
            end
        end
    end

    assign row_valid_o = row_valid_q;
    assign row_data_o  = row_data_q;
    assign row_last_o  = row_valid_q && (row_cnt_q == rows_q - 16'd1);
    assign busy_o      = (state_q == COLLECT);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// tb/tb_systolic_output_collector.sv - scoreboard bench for systolic_output_collector

module tb_systolic_output_collector;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [15:0]   rows_i = '0;
    logic [N-1:0]  col_valid_i = '0;
    logic [N*DW-1:0] col_data_i = '0;
    logic          row_valid_o;
    logic          row_ready_i = 1'b1;
    logic [N*DW-1:0] row_data_o;
    logic          row_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    systolic_output_collector #(.N(N), .DATA_W(DW), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .rows_i      (rows_i),
        .col_valid_i (col_valid_i),
        .col_data_i  (col_data_i),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_data_o  (row_data_o),
        .row_last_o  (row_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    logic ready_dflt = 1'b1;
    logic [64:0] exp_q [$];
    logic [DW-1:0] tile [8][N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef OUT_COLLECTOR_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Output monitor: scoreboard compare on handshake, stability under back-pressure.
    initial begin
        logic [N*DW-1:0] prev_data;
        logic prev_stall;
        logic [64:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(row_valid_o), 64'd1);
                    check("hold_data", row_data_o, prev_data);
                end
                prev_stall = row_valid_o && !row_ready_i;
                prev_data  = row_data_o;
                if (done_o) done_cnt++;
                if (row_valid_o && row_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_row", row_data_o, 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        check("row_data", row_data_o, e[63:0]);
                        check("row_last", 64'(row_last_o), 64'(e[64]));
                    end
                end
            end
        end
    end

    task automatic start_tile(input int m);
        @(posedge clk); #1;
        start_i = 1'b1;
        rows_i  = 16'(m);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic fill_tile();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < N; j++)
                tile[r][j] = DW'($urandom);
    endtask

    // Skewed injection: column j carries row t-j in cycle t.
    task automatic send_tile(input int m, input int n_send, input int stall_at, input int stall_len);
        logic [64:0] e;
        for (int t = 0; t < n_send + N - 1; t++) begin
            @(posedge clk); #1;
            col_valid_i = '0;
            col_data_i  = '0;
            for (int j = 0; j < N; j++) begin
                if (t - j >= 0 && t - j < n_send) begin
                    col_valid_i[j] = 1'b1;
                    col_data_i[j*DW +: DW] = tile[t-j][j];
                end
            end
            if (t < n_send && t < m) begin
                e = '0;
                for (int j = 0; j < N; j++) e[j*DW +: DW] = relu(tile[t][j]);
                e[64] = (t == m - 1);
                exp_q.push_back(e);
            end
            row_ready_i = (stall_len > 0 && t >= stall_at && t < stall_at + stall_len) ? 1'b0 : ready_dflt;
        end
        @(posedge clk); #1;
        col_valid_i = '0;
        col_data_i  = '0;
        row_ready_i = ready_dflt;
    endtask

    task automatic wait_done(input string tag, input int done_before);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy_o && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #2;
        check({tag, "_finished"}, 64'(ok), 64'd1);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(done_before + 1));
    endtask

    initial begin
        int d0;
        logic [64:0] e;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({row_valid_o, row_last_o, busy_o, done_o, err_o}), 64'd0);
        check("rst_data", row_data_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-row tile with latency checks.
        start_tile(1);
        check("start_busy", 64'(busy_o), 64'd1);
        e = {1'b1, 64'h0400_0300_0200_0100};
        for (int j = 0; j < N; j++) begin
            @(posedge clk); #1;
            col_valid_i = N'(1 << j);
            col_data_i  = '0;
            col_data_i[j*DW +: DW] = DW'(16'h0100 * (j + 1));
            if (j == 0) exp_q.push_back(e);
        end
        @(posedge clk); #1;
        col_valid_i = '0;
        check("lat_k1_valid", 64'(row_valid_o), 64'd0);
        @(posedge clk); #1;
        check("lat_k2_valid", 64'(row_valid_o), 64'd1);
        check("lat_k2_data", row_data_o, 64'h0400_0300_0200_0100);
        check("lat_k2_last", 64'(row_last_o), 64'd1);
        @(posedge clk); #1;
        check("m1_done", 64'(done_o), 64'd1);
        check("m1_valid_drop", 64'(row_valid_o), 64'd0);
        @(posedge clk); #1;
        check("m1_done_pulse", 64'(done_o), 64'd0);
        check("m1_busy", 64'(busy_o), 64'd0);

        // Four rows, ready held high.
        fill_tile();
        d0 = done_cnt;
        start_tile(4);
        send_tile(4, 4, 0, 0);
        wait_done("m4", d0);
        check("m4_err", 64'(err_o), 64'd0);

        // Four rows with a 3-cycle back-pressure window.
        fill_tile();
        d0 = done_cnt;
        start_tile(4);
        send_tile(4, 4, 3, 3);
        wait_done("stall", d0);
        check("stall_err", 64'(err_o), 64'd0);

        // Overflow: ready low while six rows stream; the sixth is dropped in every column.
        fill_tile();
        d0 = done_cnt;
        ready_dflt  = 1'b0;
        start_tile(5);
        row_ready_i = 1'b0;
        send_tile(5, 6, 0, 0);
        check("ovf_err", 64'(err_o), 64'd1);
        ready_dflt  = 1'b1;
        row_ready_i = 1'b1;
        wait_done("ovf", d0);
        check("ovf_err_sticky", 64'(err_o), 64'd1);
        fill_tile();
        d0 = done_cnt;
        start_tile(2);
        check("ovf_err_cleared", 64'(err_o), 64'd0);
        send_tile(2, 2, 0, 0);
        wait_done("post_ovf", d0);

        // Stray valid while idle, then zero-row start.
        @(posedge clk); #1;
        col_valid_i = 4'b0001;
        @(posedge clk); #1;
        col_valid_i = '0;
        check("idle_err", 64'(err_o), 64'd1);
        check("idle_no_row", 64'(row_valid_o), 64'd0);
        start_tile(0);
        check("zero_done", 64'(done_o), 64'd1);
        check("zero_busy", 64'(busy_o), 64'd0);
        check("zero_err_clr", 64'(err_o), 64'd0);
        @(posedge clk); #1;
        check("zero_done_pulse", 64'(done_o), 64'd0);
        check("zero_busy2", 64'(busy_o), 64'd0);

        // Reset mid-tile with rows queued.
        fill_tile();
        ready_dflt  = 1'b0;
        start_tile(4);
        row_ready_i = 1'b0;
        send_tile(4, 2, 0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({row_valid_o, row_last_o, busy_o, done_o, err_o}), 64'd0);
        check("mid_rst_data", row_data_o, 64'd0);
        exp_q.delete();
        ready_dflt  = 1'b1;
        row_ready_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fresh tile after reset, including a negative element.
        fill_tile();
        tile[0][0] = 16'hFF00;
        d0 = done_cnt;
        start_tile(3);
        send_tile(3, 3, 0, 0);
        wait_done("post_rst", d0);
        check("post_rst_err", 64'(err_o), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Receive end of the tiny-TPU output path: captures skewed Q8.8 results leaving the bottom edge of the NxN systolic array and reassembles them into whole result-matrix rows.
- Column j of row r arrives one cycle after column j-1 of the same row. The block de-skews the columns and emits one packed row per valid/ready handshake towards the writeback/unified buffer.
- Counts rows per tile and signals completion.

Parameters:
- N, 4, array width (number of result columns).
- DATA_W, 16, element width (Q8.8 signed fixed-point).
- DEPTH, 4, per-column de-skew FIFO depth; power of 2, must be >= N.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a tile, samples rows_i.
- rows_i  in  16  number of result rows M expected in this tile.
- col_valid_i  in  N  per-column valid from the array bottom edge.
- col_data_i  in  N*DATA_W  per-column data; column j occupies bits [j*DATA_W +: DATA_W].
- row_valid_o  out  1  packed row available.
- row_ready_i  in  1  downstream accepts the row.
- row_data_o  out  N*DATA_W  packed row, column 0 in the LSBs.
- row_last_o  out  1  high with the final row of the tile.
- busy_o  out  1  high in COLLECT.
- done_o  out  1  one-cycle pulse after the final row handshake.
- err_o  out  1  sticky error: overflow or stray valid; cleared only by reset or start_i.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; FIFOs empty; row counter 0; all outputs 0, including row_data_o.
- FSM IDLE:
  - start_i with rows_i != 0 -> COLLECT. Latch M, clear row counter, clear err_o.
  - start_i with rows_i == 0 -> stay IDLE and pulse done_o next cycle.
  - col_valid_i bits while IDLE are dropped and set err_o.
- FSM COLLECT:
  - col_valid_i[j]=1 pushes col_data_i[j] into FIFO j, independently per column.
  - Push when FIFO j is full and no pop occurs that cycle: the element is dropped and err_o is set. The array cannot be stalled.
  - Push and pop on a full FIFO in the same cycle is legal and is not an error.
- Row assembly:
  - Pop condition: all N FIFOs non-empty AND (row_valid_o==0 OR row_ready_i==1).
  - On pop: all FIFO heads pop together into the registered row_data_o, and row_valid_o=1.
- Output handshake:
  - row_valid_o stays high and row_data_o stays stable until row_ready_i is high.
  - A handshake with no new pop available drops row_valid_o next cycle.
  - Back-to-back rows at one row per cycle when row_ready_i is held high.
- Latency: if column N-1 of row r is valid in cycle k and the output is free, row r is on row_data_o with row_valid_o=1 in cycle k+2.
- row_last_o = row_valid_o AND (row counter == M-1).
- The row counter increments on each handshake. Final handshake: FSM -> IDLE, done_o=1 for exactly one cycle, FIFOs flushed.
- start_i while in COLLECT is ignored and sets err_o.
- Arithmetic: data passes through unmodified (bit-exact), apart from the optional feature below.

Optional Feature:
- Macro OUT_COLLECTOR_RELU_EN.
- Defined: each element is ReLU'd at the pop into row_data_o. If its sign bit is 1, the element is replaced by 0. No added latency.
- Undefined: no ReLU logic; data is bit-exact.

Test Plan:
- N=4, M=1, start; col j valid in cycle 10+j with data 0x0100*(j+1) -> row_data_o=0x0400_0300_0200_0100, row_valid_o=1 in cycle 15, row_last_o=1; done_o pulses the cycle after the handshake.
- M=4, skewed 4x4 identity-times-A stream, row_ready_i held 1 -> 4 consecutive rows match the reference matMult rows, one per cycle; err_o=0.
- M=4, row_ready_i=0 for 3 cycles mid-tile -> row_data_o holds stable; no row lost or duplicated; err_o=0 (DEPTH=4 absorbs the stall).
- Stall row_ready_i long enough that 5 elements queue in column 0 -> err_o=1 and sticky; start_i clears it.
- col_valid_i=4'b0001 while IDLE -> err_o=1, no row_valid_o; rows_i=0 start -> done_o pulse, busy_o stays 0.
- Reset asserted mid-tile with 2 rows queued -> all outputs 0 immediately; after release a new tile collects correctly. With OUT_COLLECTOR_RELU_EN, an input of 0xFF00 (-1.0) outputs 0x0000.
